// File: rtl/signed_seq_divider_if.sv
// Handshake bundle for the sequential signed divider.
//   start, dividend, divisor        : controller -> divider (request and operands)
//   busy, done, quotient, remainder,
//   div_by_zero                     : divider -> controller (status and results)
// The master modport is the issuing controller; the slave modport is the divider.
interface signed_seq_divider_if #(
  parameter int WIDTH = 8
);
  logic                    start;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
  logic                    div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/signed_seq_divider.sv
// Sequential signed integer divider (restoring shift/subtract on magnitudes,
// one quotient bit per clock). Truncates toward zero like Verilog signed / and %.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; drops any operation in flight
//   bus (slave)  start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
// Timing: start accepted in IDLE at edge t0 -> done pulses after edge t0+WIDTH+1
// (t0+1 for a zero divisor). Results and div_by_zero hold until the next done.
module signed_seq_divider #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  signed_seq_divider_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WIDTH:0] ONE_M    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Divisor magnitude is widened by one bit so -2^(WIDTH-1) negates without overflow.
  function automatic logic [WIDTH:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? (~ext + ONE_M) : ext;
  endfunction

  // Re-applies a sign to a magnitude; wraps modulo 2^WIDTH, which is what makes
  // -2^(WIDTH-1) / -1 come out as -2^(WIDTH-1).
  function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                         input logic [WIDTH-1:0] m);
    return neg ? $signed(~m + ONE_W) : $signed(m);
  endfunction

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   dsr;
  logic [WIDTH-1:0] quo;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic [WIDTH:0]   dsr_mag;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             trial_ok;

  // An unsigned WIDTH-bit negate already yields 2^(WIDTH-1) for the most negative
  // dividend, so the dividend magnitude needs no extra bit.
  always_comb begin
    dsr_mag  = magnitude(bus.divisor);
    dvd_mag  = bus.dividend[WIDTH-1] ? ($unsigned(~bus.dividend) + ONE_W)
                                     : $unsigned(bus.dividend);
    shifted  = {rem, quo[WIDTH-1]};
    trial_ok = shifted >= {1'b0, dsr};
    diff     = shifted[WIDTH:0] - dsr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rem             <= '0;
      dsr             <= '0;
      quo             <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      dz              <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        // Accept: capture signs and magnitudes, or take the zero-divisor shortcut.
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            q_neg    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg    <= bus.dividend[WIDTH-1];
            dsr      <= dsr_mag;
            rem      <= '0;
            cnt      <= CNT_INIT;
            if (bus.divisor == '0) begin
              // Raw dividend is parked in quo; it becomes the remainder.
              dz    <= 1'b1;
              quo   <= $unsigned(bus.dividend);
              state <= FIN;
            end else begin
              dz    <= 1'b0;
              quo   <= dvd_mag;
              state <= CALC;
            end
          end
        end
        // One restoring step per clock: shift {rem,quo}, keep the difference if non-negative.
        CALC: begin
          rem <= trial_ok ? diff : shifted[WIDTH:0];
          quo <= {quo[WIDTH-2:0], trial_ok};
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= FIN;
          end
        end
        // Publish results with a single done pulse.
        FIN: begin
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          bus.div_by_zero <= dz;
          if (dz) begin
            bus.quotient  <= '1;
            bus.remainder <= $signed(quo);
          end else begin
            bus.quotient  <= apply_sign(q_neg, quo);
            bus.remainder <= apply_sign(r_neg, rem[WIDTH-1:0]);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
module tb_signed_seq_divider;

  typedef struct {
    int q;
    int r;
    bit dz;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8;
  exp_t e16;

  signed_seq_divider_if #(.WIDTH(8))  bus8();
  signed_seq_divider_if #(.WIDTH(16)) bus16();

  signed_seq_divider #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(bus8));
  signed_seq_divider #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sext(input int v, input int w);
    return (v <<< (32 - w)) >>> (32 - w);
  endfunction

  // Reference: plain integer division truncating toward zero, results wrapped to w bits.
  function automatic exp_t ref_div(input int a, input int b, input int w);
    exp_t e;
    e.cyc = 0;
    if (b == 0) begin
      e.q  = -1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = sext(a / b, w);
      e.r  = sext(a % b, w);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a done pulse appears.
  always @(negedge clk) begin
    if (!rst && bus8.done) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done8_unexpected: got done at cycle %0d, required none", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("quot8", int'(bus8.quotient), e8.q);
        chk("rem8", int'(bus8.remainder), e8.r);
        chk("dz8", int'(bus8.div_by_zero), int'(e8.dz));
        chk("lat8", cyc, e8.cyc);
        chk("busy_at_done8", int'(bus8.busy), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus16.done) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done16_unexpected: got done at cycle %0d, required none", cyc);
      end else begin
        e16 = q16.pop_front();
        chk("quot16", int'(bus16.quotient), e16.q);
        chk("rem16", int'(bus16.remainder), e16.r);
        chk("dz16", int'(bus16.div_by_zero), int'(e16.dz));
        chk("lat16", cyc, e16.cyc);
        chk("busy_at_done16", int'(bus16.busy), 0);
      end
    end
  end

  task automatic wait_idle8();
    int w = 0;
    while ((q8.size() != 0 || bus8.busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle8_timeout: got %0d pending, required 0", q8.size());
    end
  endtask

  task automatic wait_idle16();
    int w = 0;
    while ((q16.size() != 0 || bus16.busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle16_timeout: got %0d pending, required 0", q16.size());
    end
  endtask

  // Issue one op once the divider is idle; pushes the expected result and done cycle.
  task automatic op8(input int a, input int b);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (bus8.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy8_timeout: got busy=1, required 0");
    end
    bus8.dividend = 8'(a);
    bus8.divisor  = 8'(b);
    bus8.start    = 1'b1;
    e = ref_div(sext(a, 8), sext(b, 8), 8);
    e.cyc = cyc + 1 + (e.dz ? 1 : 9);
    q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic op16(input int a, input int b);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (bus16.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy16_timeout: got busy=1, required 0");
    end
    bus16.dividend = 16'(a);
    bus16.divisor  = 16'(b);
    bus16.start    = 1'b1;
    e = ref_div(sext(a, 16), sext(b, 16), 16);
    e.cyc = cyc + 1 + (e.dz ? 1 : 17);
    q16.push_back(e);
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_busy"}, int'(bus8.busy), 0);
    chk({tag, "_done"}, int'(bus8.done), 0);
    chk({tag, "_quot"}, int'(bus8.quotient), 0);
    chk({tag, "_rem"}, int'(bus8.remainder), 0);
    chk({tag, "_dz"}, int'(bus8.div_by_zero), 0);
  endtask

  initial begin
    int c;
    exp_t e;
    bus8.start = 1'b0;
    bus8.dividend = '0;
    bus8.divisor = '0;
    bus16.start = 1'b0;
    bus16.dividend = '0;
    bus16.divisor = '0;

    repeat (3) @(negedge clk);
    chk_zero8("reset8");
    chk("reset16_busy", int'(bus16.busy), 0);
    chk("reset16_done", int'(bus16.done), 0);
    chk("reset16_quot", int'(bus16.quotient), 0);
    rst = 1'b0;

    // Signed quadrants, corners, divide by zero
    op8(100, 7);
    op8(-100, 7);
    op8(100, -7);
    op8(-100, -7);
    op8(-128, -1);
    op8(-128, 1);
    op8(127, -128);
    op8(0, 5);
    op8(5, 0);
    op8(9, 3);
    wait_idle8();

    // Second start while busy, with changed operands, must be ignored
    op8(100, 7);
    repeat (2) @(negedge clk);
    bus8.dividend = 8'sd50;
    bus8.divisor  = 8'sd5;
    bus8.start    = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_idle8();

    // start held high: back-to-back ops, one done every 10 cycles
    @(negedge clk);
    c = cyc;
    bus8.dividend = 8'sd100;
    bus8.divisor  = 8'sd7;
    bus8.start    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = ref_div(100, 7, 8);
      e.cyc = c + 1 + 10 * k + 9;
      q8.push_back(e);
    end
    repeat (21) @(negedge clk);
    bus8.start = 1'b0;
    wait_idle8();

    // Asynchronous reset mid-operation: outputs clear immediately, no done follows
    @(negedge clk);
    bus8.dividend = -8'sd100;
    bus8.divisor  = 8'sd7;
    bus8.start    = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero8("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_reset_busy", int'(bus8.busy), 0);
    op8(-100, 7);
    wait_idle8();

    // Sweep, 8 bits
    for (int i = 0; i <= 20; i++) op8(7 * i, 11 * i - 50);
    wait_idle8();

    // Random 8-bit ops with some forced corners
    for (int k = 0; k < 40; k++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if (k % 10 == 3) b = 0;
      if (k % 10 == 7) begin
        a = 128;
        b = 255;
      end
      op8(a, b);
    end
    wait_idle8();

    // Sweep and random ops, 16 bits
    for (int i = 0; i <= 20; i++) op16(7 * i, 11 * i - 50);
    op16(-32768, -1);
    op16(-32768, 1);
    op16(1234, 0);
    op16(32767, -32768);
    for (int k = 0; k < 20; k++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      if (k % 5 == 2) b = int'($urandom_range(0, 15));
      op16(a, b);
    end
    wait_idle16();
    wait_idle8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
